// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the 3x3 MAC-tree sequencer: FSM encoding, tag layout and
// the default tree latency.
package conv_ctrl_pkg;

  // Tree = one multiplier stage group plus a 4-level adder tree over 9 products.
  localparam int unsigned TREE_MULT_LAT    = 4;
  localparam int unsigned TREE_ADD_LAT     = 4;
  localparam int unsigned DEFAULT_PIPE_LAT = TREE_MULT_LAT + TREE_ADD_LAT;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Tag = {flags, col}; flags sit in the MSBs so valid is always the top bit.
  localparam int unsigned TAG_FLAG_W = 3;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_flags_t;

  function automatic tag_flags_t make_flags(logic valid, logic first, logic last);
    tag_flags_t f;
    f.valid = valid;
    f.first = first;
    f.last  = last;
    return f;
  endfunction

endpackage

// File: rtl/conv3x3_mac_ctrl_if.sv
// Control/handshake bundle between the MAC-tree sequencer and its surroundings.
interface conv3x3_mac_ctrl_if #(
  parameter int unsigned CH_W  = 10,
  parameter int unsigned COL_W = 10
);
  logic             start;
  logic [CH_W-1:0]  cfg_in_ch;
  logic [COL_W-1:0] cfg_cols;
  logic             win_valid;
  logic             win_ready;
  logic             w_rd_en;
  logic [CH_W-1:0]  w_rd_addr;
  logic             tree_vld;
  logic             acc_load;
  logic             acc_en;
  logic             out_valid;
  logic [COL_W-1:0] out_col;
  logic             busy;
  logic             done;

  modport master (
    input  start, cfg_in_ch, cfg_cols, win_valid,
    output win_ready, w_rd_en, w_rd_addr, tree_vld, acc_load, acc_en,
           out_valid, out_col, busy, done
  );

  modport slave (
    output start, cfg_in_ch, cfg_cols, win_valid,
    input  win_ready, w_rd_en, w_rd_addr, tree_vld, acc_load, acc_en,
           out_valid, out_col, busy, done
  );

endinterface

// File: rtl/tag_delay_line.sv
// Fixed-depth tag shift register that mirrors the MAC tree's pipeline latency.
module tag_delay_line
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_PIPE_LAT,
  parameter int unsigned TAG_W = 13
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
  output logic             any_valid
);

  logic [TAG_W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | stage_q[i][TAG_W-1];
    end
  end

  assign out_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/conv3x3_mac_ctrl.sv
// Sequencer for the 3x3 SIMD multiply-add tree: issues channel beats per column, tracks
// them through the tree latency and drives accumulator load/add/emit strobes.
module conv3x3_mac_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_LAT = DEFAULT_PIPE_LAT,
  parameter int unsigned CH_W     = 10,
  parameter int unsigned COL_W    = 10
) (
  input logic               clk,
  input logic               rst,
  conv3x3_mac_ctrl_if.master bus
);

  localparam int unsigned TAG_W     = TAG_FLAG_W + COL_W;
  localparam int unsigned VALID_BIT = TAG_W - 1;

  logic [1:0]       state_q, state_d;
  logic [CH_W-1:0]  in_ch_q, ch_cnt_q, ch_cnt_d, ch_last;
  logic [COL_W-1:0] cols_q, col_cnt_q, col_cnt_d, col_last;
  logic [TAG_W-1:0] s0_q, s0_d, exit_tag;
  tag_flags_t       exit_flags;
  logic             dl_any_valid;
  logic             win_ready, hs, beat_first, beat_last, pass_last, cfg_zero;
  logic             out_valid_q;
  logic [COL_W-1:0] out_col_q;

  assign ch_last    = in_ch_q - CH_W'(1);
  assign col_last   = cols_q - COL_W'(1);
  assign win_ready  = (state_q == StRun);
  assign hs         = bus.win_valid & win_ready;
  assign beat_first = (ch_cnt_q == '0);
  assign beat_last  = (ch_cnt_q == ch_last);
  assign pass_last  = beat_last & (col_cnt_q == col_last);
  assign cfg_zero   = (bus.cfg_in_ch == '0) | (bus.cfg_cols == '0);

  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    col_cnt_d = col_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          ch_cnt_d  = '0;
          col_cnt_d = '0;
          state_d   = cfg_zero ? StDone : StRun;
        end
      end
      StRun: begin
        if (hs) begin
          if (beat_last) begin
            ch_cnt_d = '0;
            if (pass_last) begin
              state_d = StDrain;
            end else begin
              col_cnt_d = col_cnt_q + COL_W'(1);
            end
          end else begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
          end
        end
      end
      StDrain: begin
        // The final column's out_valid is the last event of a pass; wait for it to fire.
        if (!s0_q[VALID_BIT] && !dl_any_valid && out_valid_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s0_d = '0;
    if (hs) begin
      s0_d = {make_flags(1'b1, beat_first, beat_last), col_cnt_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ch_cnt_q  <= '0;
      col_cnt_q <= '0;
      in_ch_q   <= '0;
      cols_q    <= '0;
      s0_q      <= '0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      col_cnt_q <= col_cnt_d;
      s0_q      <= s0_d;
      if (state_q == StIdle && bus.start) begin
        in_ch_q <= bus.cfg_in_ch;
        cols_q  <= bus.cfg_cols;
      end
    end
  end

  tag_delay_line #(
    .DEPTH (PIPE_LAT),
    .TAG_W (TAG_W)
  ) u_tag_delay_line (
    .clk       (clk),
    .clr       (rst),
    .in_tag    (s0_q),
    .out_tag   (exit_tag),
    .any_valid (dl_any_valid)
  );

  assign exit_flags = exit_tag[TAG_W-1 -: TAG_FLAG_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
    end else begin
      out_valid_q <= exit_flags.valid & exit_flags.last;
      if (exit_flags.valid && exit_flags.last) begin
        out_col_q <= exit_tag[COL_W-1:0];
      end
    end
  end

  assign bus.win_ready = win_ready;
  assign bus.w_rd_en   = hs;
  assign bus.w_rd_addr = ch_cnt_q;
  assign bus.tree_vld  = s0_q[VALID_BIT];
  assign bus.acc_en    = exit_flags.valid;
  assign bus.acc_load  = exit_flags.valid & exit_flags.first;
  assign bus.out_valid = out_valid_q;
  assign bus.out_col   = out_col_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_conv3x3_mac_ctrl.sv
// Self-checking bench for conv3x3_mac_ctrl: timeline reference model plus directed and
// randomized passes.
module tb_conv3x3_mac_ctrl;
  localparam int unsigned P     = 8;
  localparam int unsigned CH_W  = 10;
  localparam int unsigned COL_W = 10;
  localparam int          RB    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv3x3_mac_ctrl_if #(.CH_W(CH_W), .COL_W(COL_W)) bus ();

  conv3x3_mac_ctrl #(.PIPE_LAT(P), .CH_W(CH_W), .COL_W(COL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: expected events placed on a cycle timeline.
  bit e_tv [RB];
  bit e_ae [RB];
  bit e_al [RB];
  bit e_ov [RB];
  int e_oc [RB];
  bit m_started = 1'b0;
  int m_start = 0, m_done = 0, m_n = 0, m_k = 0, m_in = 1;

  always @(negedge clk) begin
    int idx, ch, col;
    bit act, wr, hs;
    idx = cyc % RB;
    if (rst) begin
      for (int i = 0; i < RB; i++) begin
        e_tv[i] = 0; e_ae[i] = 0; e_al[i] = 0; e_ov[i] = 0; e_oc[i] = 0;
      end
      m_started = 1'b0;
    end else begin
      act = m_started && cyc > m_start && (m_done < 0 || cyc <= m_done);
      wr  = act && (m_k < m_n);
      hs  = wr && bus.win_valid;
      chk("win_ready", bus.win_ready, wr);
      chk("w_rd_en", bus.w_rd_en, hs);
      chk("tree_vld", bus.tree_vld, e_tv[idx]);
      chk("acc_en", bus.acc_en, e_ae[idx]);
      chk("acc_load", bus.acc_load, e_al[idx]);
      chk("out_valid", bus.out_valid, e_ov[idx]);
      if (e_ov[idx]) chk("out_col", bus.out_col, e_oc[idx]);
      chk("busy", bus.busy, act);
      chk("done", bus.done, act && cyc == m_done);
      if (hs) begin
        ch  = m_k % m_in;
        col = m_k / m_in;
        chk("w_rd_addr", bus.w_rd_addr, ch);
        e_tv[(cyc + 1) % RB]     = 1;
        e_ae[(cyc + 1 + P) % RB] = 1;
        e_al[(cyc + 1 + P) % RB] = (ch == 0);
        if (ch == m_in - 1) begin
          e_ov[(cyc + 2 + P) % RB] = 1;
          e_oc[(cyc + 2 + P) % RB] = col;
        end
        m_k++;
        if (m_k == m_n) m_done = cyc + 3 + P;
      end
      if (bus.start && !act) begin
        m_started = 1'b1;
        m_start   = cyc;
        m_k       = 0;
        if (bus.cfg_in_ch == 0 || bus.cfg_cols == 0) begin
          m_n    = 0;
          m_done = cyc + 1;
        end else begin
          m_in   = int'(bus.cfg_in_ch);
          m_n    = int'(bus.cfg_in_ch) * int'(bus.cfg_cols);
          m_done = -1;
        end
      end
      e_tv[idx] = 0; e_ae[idx] = 0; e_al[idx] = 0; e_ov[idx] = 0; e_oc[idx] = 0;
    end
  end

  // Event log of what the DUT actually did, for the literal per-test expectations.
  int n_hs, n_wr, n_ae, n_al, n_ov, n_done, first_hs, done_at;
  int ov_cyc[$];
  int ov_col[$];
  int al_cyc[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.w_rd_en) begin
        if (n_hs == 0) first_hs = cyc;
        n_hs++;
      end
      if (bus.win_ready) n_wr++;
      if (bus.acc_en) n_ae++;
      if (bus.acc_load) begin
        n_al++;
        al_cyc.push_back(cyc);
      end
      if (bus.out_valid) begin
        n_ov++;
        ov_cyc.push_back(cyc);
        ov_col.push_back(int'(bus.out_col));
      end
      if (bus.done) begin
        n_done++;
        done_at = cyc;
      end
    end
  end

  task automatic clear_mon();
    n_hs = 0; n_wr = 0; n_ae = 0; n_al = 0; n_ov = 0; n_done = 0;
    first_hs = -1; done_at = -1;
    ov_cyc.delete(); ov_col.delete(); al_cyc.delete();
  endtask

  // win_valid pattern: 0 = held high, 1 = toggling, 2 = random, 3 = held low.
  int vmode = 3;
  bit tog = 1'b0;
  always @(posedge clk) begin
    #1;
    case (vmode)
      0: bus.win_valid = 1'b1;
      1: begin tog = ~tog; bus.win_valid = tog; end
      2: bus.win_valid = ($urandom_range(0, 2) != 0);
      default: bus.win_valid = 1'b0;
    endcase
  end

  int s_cyc;

  task automatic pulse_start(int in_ch, int cols);
    @(posedge clk); #1;
    bus.cfg_in_ch = CH_W'(in_ch);
    bus.cfg_cols  = COL_W'(cols);
    bus.start     = 1'b1;
    s_cyc         = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(int bound);
    int base;
    base = n_done;
    for (int i = 0; i < bound && n_done == base; i++) @(posedge clk);
    chk("done_seen", (n_done != base) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.cfg_in_ch = '0;
    bus.cfg_cols  = '0;
    bus.win_valid = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_win_ready", bus.win_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_acc_en", bus.acc_en, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_col", bus.out_col, 0);
    chk("rst_w_rd_addr", bus.w_rd_addr, 0);

    // 2 columns x 3 channels, win_valid always high.
    clear_mon(); vmode = 0;
    pulse_start(3, 2);
    wait_done(200);
    chk("t1_first_hs", first_hs - s_cyc, 1);
    chk("t1_acc_en_cnt", n_ae, 6);
    chk("t1_acc_load_cnt", n_al, 2);
    chk("t1_ov_cnt", n_ov, 2);
    if (al_cyc.size() == 2) begin
      chk("t1_load0", al_cyc[0] - first_hs, 9);
      chk("t1_load1", al_cyc[1] - first_hs, 12);
    end
    if (ov_cyc.size() == 2) begin
      chk("t1_ov0", ov_cyc[0] - first_hs, 12);
      chk("t1_ov1", ov_cyc[1] - first_hs, 15);
      chk("t1_col0", ov_col[0], 0);
      chk("t1_col1", ov_col[1], 1);
    end
    chk("t1_done", done_at - first_hs, 16);

    // Same pass with toggling win_valid.
    clear_mon(); vmode = 1;
    pulse_start(3, 2);
    wait_done(200);
    chk("t2_acc_en_cnt", n_ae, 6);
    chk("t2_acc_load_cnt", n_al, 2);
    chk("t2_ov_cnt", n_ov, 2);

    // Zero channel count: straight to DONE.
    clear_mon(); vmode = 0;
    pulse_start(0, 3);
    wait_done(20);
    chk("t3_done_at", done_at - s_cyc, 1);
    chk("t3_win_ready_cnt", n_wr, 0);
    chk("t3_acc_en_cnt", n_ae, 0);
    chk("t3_ov_cnt", n_ov, 0);

    // One channel, four columns.
    clear_mon(); vmode = 0;
    pulse_start(1, 4);
    wait_done(200);
    chk("t4_acc_en_cnt", n_ae, 4);
    chk("t4_acc_load_cnt", n_al, 4);
    chk("t4_ov_cnt", n_ov, 4);
    if (ov_col.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t4_out_col", ov_col[i], i);
    end

    // Reset two cycles after the third handshake.
    clear_mon(); vmode = 0;
    pulse_start(3, 2);
    for (int i = 0; i < 100 && n_hs < 3; i++) @(posedge clk);
    chk("t5_three_hs", n_hs, 3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_win_ready", bus.win_ready, 0);
    chk("t5_w_rd_en", bus.w_rd_en, 0);
    chk("t5_tree_vld", bus.tree_vld, 0);
    chk("t5_acc_en", bus.acc_en, 0);
    chk("t5_acc_load", bus.acc_load, 0);
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_out_col", bus.out_col, 0);
    clear_mon();
    repeat (20) @(posedge clk);
    chk("t5_acc_en_after", n_ae, 0);
    chk("t5_ov_after", n_ov, 0);

    // start during RUN with a different cfg is ignored.
    clear_mon(); vmode = 0;
    pulse_start(3, 2);
    @(posedge clk); #1;
    bus.cfg_in_ch = CH_W'(1);
    bus.cfg_cols  = COL_W'(1);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(200);
    repeat (5) @(posedge clk);
    chk("t6_done_cnt", n_done, 1);
    chk("t6_acc_en_cnt", n_ae, 6);
    chk("t6_ov_cnt", n_ov, 2);

    // Randomized passes against the model.
    vmode = 2;
    for (int it = 0; it < 12; it++) begin
      int ic, cc;
      clear_mon();
      ic = $urandom_range(0, 4);
      cc = $urandom_range(0, 4);
      pulse_start(ic, cc);
      wait_done(500);
      chk("rnd_acc_en_cnt", n_ae, ic * cc);
      chk("rnd_ov_cnt", n_ov, (ic == 0) ? 0 : cc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
